// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI definitions for the master and slave endpoints.
//   spi_s_state_t : slave FSM states.
//   SPI_BYTE_W    : frame width in bits.
//   SPI_CPOL/CPHA : link mode (mode 0), shared so both ends agree.
package spi_pkg;

    localparam int   SPI_BYTE_W = 8;
    localparam logic SPI_CPOL   = 1'b0;
    localparam logic SPI_CPHA   = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT
    } spi_s_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: N-flop synchronizer for an asynchronous input plus
// single-cycle rise/fall detection on the synchronized level.
//   clk, rst_l : system clock, synchronous active-low reset
//   i_din      : asynchronous input
//   o_level    : synchronized level
//   o_rise     : one-cycle pulse on a synchronized 0->1
//   o_fall     : one-cycle pulse on a synchronized 1->0
// The chain and the edge history are preset to RESET_VAL so that leaving
// reset with the input at its idle level produces no spurious edge.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_l,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-0, MSB-first, 8-bit SPI responder. SCLK, CS_L and MOSI
// are oversampled on clk; nothing is clocked by SCLK.
//   clk, rst_l          : system clock, synchronous active-low reset
//   SCLK, CS_L, MOSI    : asynchronous SPI inputs from the master
//   MISO, miso_oe       : data to the master and its output enable
//   tx_data, tx_empty   : head / empty flag of an FWFT TX FIFO
//   tx_rd_en            : one-cycle TX FIFO pop
//   rx_data, rx_valid   : received byte and its one-cycle push strobe
//   tx_underrun         : one-cycle pulse when a load found the TX FIFO empty
module spi_slave
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       SCLK,
    input  logic       CS_L,
    input  logic       MOSI,
    output logic       MISO,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_empty,
    output logic       tx_rd_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun
);

    // Mode 0/3 sample on the rising edge, modes 1/2 on the falling edge.
    localparam logic       SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);
    localparam logic [3:0] LAST_BIT       = 4'(SPI_BYTE_W - 1);
    localparam logic [3:0] FULL_CNT       = 4'(SPI_BYTE_W);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_high, w_cs_rise, w_cs_fall;
    logic w_mosi, w_sample_edge, w_shift_edge, w_deselect;
    logic w_load;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    spi_s_state_t           r_state, w_state_nxt;
    logic [3:0]             r_bit_cnt;
    logic                   r_byte_done;
    logic [SPI_BYTE_W-1:0]  r_shift_tx, r_shift_rx, r_rx_data;
    logic                   r_rx_valid;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sclk_sync (
        .clk(clk), .rst_l(rst_l), .i_din(SCLK),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_l(rst_l), .i_din(CS_L),
        .o_level(w_cs_high), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    // MOSI chain has the same depth as the SCLK chain so the sampled bit is
    // phase-aligned with the detected SCLK edge.
    always_ff @(posedge clk) begin
        if (!rst_l) r_mosi_sync <= '0;
        else        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_sample_edge = SAMPLE_ON_RISE ? w_sclk_rise : w_sclk_fall;
    assign w_shift_edge  = SAMPLE_ON_RISE ? w_sclk_fall : w_sclk_rise;
    assign w_deselect    = w_cs_high | w_cs_rise;

    always_ff @(posedge clk) begin
        if (!rst_l) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Deselect wins over any SCLK edge seen in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        tx_rd_en    = 1'b0;
        tx_underrun = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_deselect) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_load      = 1'b1;
                    tx_rd_en    = ~tx_empty;
                    tx_underrun = tx_empty;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_deselect)                      w_state_nxt = S_IDLE;
                else if (w_shift_edge && r_byte_done) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
            r_shift_tx  <= '0;
            r_shift_rx  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_load) begin
                r_shift_tx  <= tx_empty ? UNDERRUN_BYTE : tx_data;
                r_bit_cnt   <= '0;
                r_byte_done <= 1'b0;
            end else if (r_state == S_SHIFT && !w_deselect) begin
                if (w_sample_edge && r_bit_cnt < FULL_CNT) begin
                    r_shift_rx <= {r_shift_rx[SPI_BYTE_W-2:0], w_mosi};
                    r_bit_cnt  <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == LAST_BIT) begin
                        r_rx_data   <= {r_shift_rx[SPI_BYTE_W-2:0], w_mosi};
                        r_rx_valid  <= 1'b1;
                        r_byte_done <= 1'b1;
                    end
                end
                // After the last bit the TX register is left alone; the
                // following load replaces it.
                if (w_shift_edge && !r_byte_done)
                    r_shift_tx <= {r_shift_tx[SPI_BYTE_W-2:0], 1'b0};
            end
        end
    end

    assign MISO     = (r_state == S_SHIFT) & r_shift_tx[SPI_BYTE_W-1];
    assign miso_oe  = (r_state != S_IDLE);
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       SCLK, CS_L, MOSI;
    logic       MISO, miso_oe;
    logic [7:0] tx_data;
    logic       tx_empty;
    logic       tx_rd_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;

    always #5 clk = ~clk;

    spi_slave #(.SYNC_STAGES(2), .UNDERRUN_BYTE(8'hFF)) dut (
        .clk(clk), .rst_l(rst_l), .SCLK(SCLK), .CS_L(CS_L), .MOSI(MOSI),
        .MISO(MISO), .miso_oe(miso_oe), .tx_data(tx_data), .tx_empty(tx_empty),
        .tx_rd_en(tx_rd_en), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // TX FIFO model (FWFT) and RX/strobe monitor. The pop is applied one
    // cycle after the strobe so the DUT samples the head it popped.
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int         n_rd  = 0;
    int         n_udr = 0;
    bit         pop_pend = 0;
    logic [7:0] dummy;

    always @(negedge clk) begin
        if (pop_pend && tx_q.size() > 0) dummy = tx_q.pop_front();
        pop_pend = tx_rd_en;
        if (tx_rd_en)    n_rd++;
        if (tx_underrun) n_udr++;
        if (rx_valid)    rx_q.push_back(rx_data);
        tx_empty = (tx_q.size() == 0);
        tx_data  = tx_empty ? 8'h00 : tx_q[0];
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        rx_q.delete();
        n_rd  = 0;
        n_udr = 0;
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD_BEEF;
    endfunction

    // Master side: SCLK = clk/8, MOSI set half a period before each rise,
    // MISO sampled at the rise. When 'last' is set, CS_L rises together with
    // the final SCLK fall.
    task automatic master_xfer(input logic [7:0] mo, input int nbits, input bit last,
                               output logic [7:0] mi);
        mi = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            MOSI = mo[7-k];
            wait_clk(4);
            mi[7-k] = MISO;
            SCLK = 1'b1;
            wait_clk(4);
            SCLK = 1'b0;
            if (last && k == nbits - 1) CS_L = 1'b1;
        end
    endtask

    logic [7:0] mi, m0, m1, m2;
    logic [7:0] r_mo[256];
    logic [7:0] r_tx[256];

    initial begin
        rst_l = 1'b0; SCLK = 1'b0; CS_L = 1'b1; MOSI = 1'b0;
        tx_empty = 1'b1; tx_data = 8'h00;
        wait_clk(3);
        chk("rst_miso", MISO, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_tx_rd_en", tx_rd_en, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_underrun", tx_underrun, 0);
        rst_l = 1'b1;
        wait_clk(5);

        // Single byte
        clr();
        tx_q.push_back(8'hA5);
        wait_clk(2);
        CS_L = 1'b0;
        master_xfer(8'h3C, 8, 1, mi);
        wait_clk(10);
        chk("single_miso", mi, 8'hA5);
        chk("single_rx_cnt", rx_q.size(), 1);
        chk("single_rx_data", rx_at(0), 8'h3C);
        chk("single_rd_cnt", n_rd, 1);
        chk("single_udr_cnt", n_udr, 0);
        chk("single_oe_idle", miso_oe, 0);

        // Burst of three under one CS_L
        clr();
        tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
        wait_clk(2);
        CS_L = 1'b0;
        master_xfer(8'hC0, 8, 0, m0);
        master_xfer(8'hC1, 8, 0, m1);
        master_xfer(8'hC2, 8, 1, m2);
        wait_clk(10);
        chk("burst_miso0", m0, 8'h11);
        chk("burst_miso1", m1, 8'h22);
        chk("burst_miso2", m2, 8'h33);
        chk("burst_rx_cnt", rx_q.size(), 3);
        chk("burst_rx0", rx_at(0), 8'hC0);
        chk("burst_rx1", rx_at(1), 8'hC1);
        chk("burst_rx2", rx_at(2), 8'hC2);
        chk("burst_rd_cnt", n_rd, 3);

        // Underrun
        clr();
        wait_clk(2);
        CS_L = 1'b0;
        master_xfer(8'h55, 8, 1, mi);
        wait_clk(10);
        chk("udr_miso", mi, 8'hFF);
        chk("udr_cnt", n_udr, 1);
        chk("udr_rd_cnt", n_rd, 0);
        chk("udr_rx_cnt", rx_q.size(), 1);
        chk("udr_rx_data", rx_at(0), 8'h55);

        // Abort after five bits, then a full byte
        clr();
        tx_q.push_back(8'h99);
        wait_clk(2);
        CS_L = 1'b0;
        master_xfer(8'hF0, 5, 1, mi);
        wait_clk(4);
        chk("abort_oe_off", miso_oe, 0);
        wait_clk(6);
        chk("abort_rx_cnt", rx_q.size(), 0);
        tx_q.push_back(8'h5A);
        wait_clk(2);
        CS_L = 1'b0;
        master_xfer(8'h0F, 8, 1, mi);
        wait_clk(10);
        chk("abort_next_rx_cnt", rx_q.size(), 1);
        chk("abort_next_rx", rx_at(0), 8'h0F);
        chk("abort_next_miso", mi, 8'h5A);

        // Reset in the middle of a byte (TX FIFO left empty)
        clr();
        wait_clk(2);
        CS_L = 1'b0;
        master_xfer(8'hAA, 3, 0, mi);
        rst_l = 1'b0;
        wait_clk(1);
        chk("mrst_miso", MISO, 0);
        chk("mrst_oe", miso_oe, 0);
        chk("mrst_rx_valid", rx_valid, 0);
        chk("mrst_rx_data", rx_data, 0);
        chk("mrst_rd_en", tx_rd_en, 0);
        rst_l = 1'b1;
        master_xfer(8'hAA, 5, 1, mi);
        wait_clk(10);
        chk("mrst_no_rx", rx_q.size(), 0);
        clr();
        tx_q.push_back(8'hC3);
        wait_clk(2);
        CS_L = 1'b0;
        master_xfer(8'h96, 8, 1, mi);
        wait_clk(10);
        chk("mrst_next_rx_cnt", rx_q.size(), 1);
        chk("mrst_next_rx", rx_at(0), 8'h96);
        chk("mrst_next_miso", mi, 8'hC3);

        // 256 random bytes under one CS_L at minimum SCLK period / CS setup
        clr();
        for (int i = 0; i < 256; i++) begin
            r_mo[i] = 8'($urandom_range(0, 255));
            r_tx[i] = 8'($urandom_range(0, 255));
            tx_q.push_back(r_tx[i]);
        end
        wait_clk(2);
        CS_L = 1'b0;
        for (int i = 0; i < 256; i++) begin
            master_xfer(r_mo[i], 8, (i == 255), mi);
            chk("rnd_miso", mi, r_tx[i]);
        end
        wait_clk(10);
        chk("rnd_rx_cnt", rx_q.size(), 256);
        chk("rnd_rd_cnt", n_rd, 256);
        chk("rnd_udr_cnt", n_udr, 0);
        for (int i = 0; i < 256; i++) chk("rnd_rx", rx_at(i), r_mo[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
